// File: rtl/mem_io_responder_pkg.sv
// Shared definitions for the memory/IO responder: bus widths, the IO port
// address, FIFO sizing and the access-decode result type.
package mem_io_responder_pkg;

    localparam int          RAM_AW  = 17;
    localparam int          FIFO_AW = 3;
    localparam logic [31:0] IO_ADDR = 32'h0003_0000;

    typedef logic [31:0]     MemBus;
    typedef logic [7:0]      RegBus;
    typedef logic [RAM_AW-1:0] RamAddrBus;
    localparam MemBus        IoAddr = IO_ADDR;

    // Where a controller access lands.
    typedef enum logic [1:0] {
        ACC_NONE = 2'd0,
        ACC_RAM  = 2'd1,
        ACC_IO   = 2'd2
    } acc_t;

endpackage

// File: rtl/mem_io_responder_byte_fifo.sv
// Byte FIFO with synchronous reset, registered storage and full/empty flags.
// Pointers carry one extra wrap bit so full and empty are distinguishable.
// The head output reads 0 whenever the FIFO is empty.
module byte_fifo #(
    parameter int AW = 3
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       push,
    input  logic [7:0] push_data,
    input  logic       pop,
    output logic [7:0] head,
    output logic       full,
    output logic       empty
);

    logic [7:0]  mem [2**AW];
    logic [AW:0] wr_ptr;
    logic [AW:0] rd_ptr;
    logic        do_push;
    logic        do_pop;

    // Flags, guarded transfers and the zero-when-empty head.
    always_comb begin
        empty   = (wr_ptr == rd_ptr);
        full    = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
        do_push = push && !full;
        do_pop  = pop && !empty;
        head    = empty ? 8'h00 : mem[rd_ptr[AW-1:0]];
    end

    // Pointer update; reset discards any transfer in the same cycle.
    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + 1'b1;
            if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
        end
    end

    // Storage write; no reset so it maps onto plain registers or RAM.
    always_ff @(posedge clk) begin
        if (do_push && !rst) mem[wr_ptr[AW-1:0]] <= push_data;
    end

endmodule

// File: rtl/mem_io_responder.sv
// Byte-wide responder behind the controller's memory port: main byte RAM,
// one IO byte port backed by TX/RX FIFOs, and the rdy stall signal.
// Every cycle with rdy_o high is exactly one access; reads return data the
// following cycle and data_o holds otherwise.
module mem_io_responder
    import mem_io_responder_pkg::*;
#(
    parameter int          RAM_AW  = mem_io_responder_pkg::RAM_AW,
    parameter logic [31:0] IO_ADDR = mem_io_responder_pkg::IO_ADDR,
    parameter int          FIFO_AW = mem_io_responder_pkg::FIFO_AW
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [31:0] addr_i,
    input  logic        wr_i,
    input  logic [7:0]  data_i,
    output logic [7:0]  data_o,
    output logic        rdy_o,
    output logic [7:0]  tx_data_o,
    output logic        tx_valid_o,
    input  logic        tx_ready_i,
    input  logic [7:0]  rx_data_i,
    input  logic        rx_valid_i,
    output logic        rx_ready_o
);

    logic [7:0]        mem [2**RAM_AW];
    logic [RAM_AW-1:0] ram_idx;
    acc_t              acc;
    logic              ram_we;
    logic              tx_push;
    logic              tx_pop;
    logic              tx_full;
    logic              tx_empty;
    logic              rx_push;
    logic              rx_pop;
    logic              rx_full;
    logic              rx_empty;
    logic [7:0]        rx_head;

    // Decode the address and derive the per-cycle strobes. Stalling on a
    // full TX FIFO means an accepted IO write always has room.
    always_comb begin
        acc = ACC_NONE;
        if (addr_i == IO_ADDR) begin
            acc = ACC_IO;
        end else if (addr_i[31:RAM_AW] == '0) begin
            acc = ACC_RAM;
        end
        ram_idx    = addr_i[RAM_AW-1:0];
        rdy_o      = !rst && !tx_full;
        ram_we     = rdy_o && (acc == ACC_RAM) && wr_i;
        tx_push    = rdy_o && (acc == ACC_IO) && wr_i;
        rx_pop     = rdy_o && (acc == ACC_IO) && !wr_i && !rx_empty;
        tx_valid_o = !tx_empty;
        tx_pop     = tx_valid_o && tx_ready_i;
        rx_ready_o = !rx_full;
        rx_push    = rx_valid_i && rx_ready_o;
    end

    // RAM write port; contents survive reset so preloaded images persist.
    always_ff @(posedge clk) begin
        if (ram_we) mem[ram_idx] <= data_i;
    end

    // Read data register: RAM byte, RX head, or zero for unmapped reads.
    always_ff @(posedge clk) begin
        if (rst) begin
            data_o <= 8'h00;
        end else if (rdy_o && !wr_i) begin
            case (acc)
                ACC_RAM: data_o <= mem[ram_idx];
                ACC_IO:  data_o <= rx_head;
                default: data_o <= 8'h00;
            endcase
        end
    end

    byte_fifo #(.AW(FIFO_AW)) u_tx_fifo (
        .clk       (clk),
        .rst       (rst),
        .push      (tx_push),
        .push_data (data_i),
        .pop       (tx_pop),
        .head      (tx_data_o),
        .full      (tx_full),
        .empty     (tx_empty)
    );

    byte_fifo #(.AW(FIFO_AW)) u_rx_fifo (
        .clk       (clk),
        .rst       (rst),
        .push      (rx_push),
        .push_data (rx_data_i),
        .pop       (rx_pop),
        .head      (rx_head),
        .full      (rx_full),
        .empty     (rx_empty)
    );

endmodule
